// File: rtl/seven_segment_monitor.sv
// Watches a multiplexed seven-segment bus and recovers the displayed hex digits, decimal points
// and frame completion once each digit's pattern has been stable long enough.
module seven_segment_monitor #(
  parameter int unsigned NUM_SEGMENTS  = 8,
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      CPU_RESETN,
  input  logic [NUM_SEGMENTS-1:0]   anode,
  input  logic [7:0]                cathode,
  output logic [4*NUM_SEGMENTS-1:0] digits,
  output logic [NUM_SEGMENTS-1:0]   digit_point,
  output logic [NUM_SEGMENTS-1:0]   digit_valid,
  output logic                      frame_done,
  output logic                      decode_err,
  output logic                      anode_err
);

  localparam int unsigned BusW = NUM_SEGMENTS + 8;
  localparam int unsigned IdxW = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1;
  localparam logic [7:0]  LastCount = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StCount, StHeld} state_e;

  logic [BusW-1:0]         sync1_q, s_q, prev_q;
  state_e                  state_q;
  logic [7:0]              count_q;
  logic [NUM_SEGMENTS-1:0] mask_q;

  logic [NUM_SEGMENTS-1:0] s_anode;
  logic [7:0]              s_cath;
  logic [6:0]              seg;
  logic                    changed, any_low, one_low, multi_low;
  logic [IdxW-1:0]         sel_idx;
  logic                    font_hit, blank;
  logic [3:0]              font_nib;
  logic [NUM_SEGMENTS-1:0] mask_set;
  logic                    capture;

  assign s_anode = s_q[BusW-1:8];
  assign s_cath  = s_q[7:0];
  assign seg     = ~s_cath[6:0];
  assign changed = (s_q != prev_q);
  assign any_low = ~&s_anode;
  assign blank   = (seg == 7'h00);
  assign capture = !changed && (state_q == StCount) && (count_q == LastCount);

  // Locate the active digit and flag patterns with more than one anode driven.
  always_comb begin
    one_low   = 1'b0;
    multi_low = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_SEGMENTS; i++) begin
      if (!s_anode[i]) begin
        if (one_low) multi_low = 1'b1;
        one_low = 1'b1;
        sel_idx = IdxW'(i);
      end
    end
    mask_set          = mask_q;
    mask_set[sel_idx] = 1'b1;
  end

  always_comb begin
    font_hit = 1'b1;
    font_nib = 4'h0;
    case (seg)
      7'h3F: font_nib = 4'h0;
      7'h06: font_nib = 4'h1;
      7'h5B: font_nib = 4'h2;
      7'h4F: font_nib = 4'h3;
      7'h66: font_nib = 4'h4;
      7'h6D: font_nib = 4'h5;
      7'h7D: font_nib = 4'h6;
      7'h07: font_nib = 4'h7;
      7'h7F: font_nib = 4'h8;
      7'h6F: font_nib = 4'h9;
      7'h77: font_nib = 4'hA;
      7'h7C: font_nib = 4'hB;
      7'h39: font_nib = 4'hC;
      7'h5E: font_nib = 4'hD;
      7'h79: font_nib = 4'hE;
      7'h71: font_nib = 4'hF;
      default: font_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync1_q     <= '1;
      s_q         <= '1;
      prev_q      <= '1;
      state_q     <= StIdle;
      count_q     <= '0;
      mask_q      <= '0;
      digits      <= '0;
      digit_point <= '0;
      digit_valid <= '0;
      frame_done  <= 1'b0;
      decode_err  <= 1'b0;
      anode_err   <= 1'b0;
    end else begin
      sync1_q    <= {anode, cathode};
      s_q        <= sync1_q;
      prev_q     <= s_q;
      frame_done <= 1'b0;
      decode_err <= 1'b0;
      anode_err  <= 1'b0;
      if (changed) begin
        count_q <= '0;
        state_q <= any_low ? StCount : StIdle;
      end else if (state_q == StCount) begin
        if (capture) begin
          state_q <= StHeld;
          if (multi_low) begin
            anode_err <= 1'b1;
          end else if (one_low) begin
            digit_point[sel_idx] <= ~s_cath[7];
            digit_valid[sel_idx] <= font_hit;
            if (font_hit) digits[{sel_idx, 2'b00} +: 4] <= font_nib;
            if (!font_hit && !blank) decode_err <= 1'b1;
            if (&mask_set) begin
              frame_done <= 1'b1;
              mask_q     <= '0;
            end else begin
              mask_q <= mask_set;
            end
          end
        end else begin
          count_q <= count_q + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_monitor.sv
// Scoreboard bench: stimulus queues hand-computed capture events, a negedge monitor checks them.
module tb_seven_segment_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  anode = 8'hFF;
  logic [7:0]  cathode = 8'hFF;
  logic [31:0] digits;
  logic [7:0]  digit_point, digit_valid;
  logic        frame_done, decode_err, anode_err;

  seven_segment_monitor #(
    .NUM_SEGMENTS (8),
    .STABLE_CYCLES(16)
  ) dut (
    .clk        (clk),
    .CPU_RESETN (rst_n),
    .anode      (anode),
    .cathode    (cathode),
    .digits     (digits),
    .digit_point(digit_point),
    .digit_valid(digit_valid),
    .frame_done (frame_done),
    .decode_err (decode_err),
    .anode_err  (anode_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] digits;
    logic [7:0]  point;
    logic [7:0]  valid;
    logic        fd;
    logic        de;
    logic        ae;
  } ev_t;

  ev_t         exp_q[$];
  int          n_vec = 0;
  int          n_miss = 0;
  logic [31:0] sh_digits = '0;
  logic [7:0]  sh_point = '0;
  logic [7:0]  sh_valid = '0;
  int unsigned cyc0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " digits"}, digits, 32'h0);
    chk({tag, " digit_point"}, {24'h0, digit_point}, 32'h0);
    chk({tag, " digit_valid"}, {24'h0, digit_valid}, 32'h0);
    chk({tag, " frame_done"}, {31'h0, frame_done}, 32'h0);
    chk({tag, " decode_err"}, {31'h0, decode_err}, 32'h0);
    chk({tag, " anode_err"}, {31'h0, anode_err}, 32'h0);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [7:0] an, input logic [7:0] ca);
    anode   = an;
    cathode = ca;
    cyc0    = cyc;
  endtask

  // Single-digit capture expected 19 edges after the last drive.
  task automatic push_cap(input int idx, input logic [3:0] nib, input logic valid,
                          input logic point, input logic fd, input logic de);
    ev_t e;
    if (valid) sh_digits[idx*4 +: 4] = nib;
    sh_valid[idx] = valid;
    sh_point[idx] = point;
    e = '{cyc: cyc0 + 19, digits: sh_digits, point: sh_point, valid: sh_valid,
          fd: fd, de: de, ae: 1'b0};
    exp_q.push_back(e);
  endtask

  task automatic push_anode_err();
    ev_t e;
    e = '{cyc: cyc0 + 19, digits: sh_digits, point: sh_point, valid: sh_valid,
          fd: 1'b0, de: 1'b0, ae: 1'b1};
    exp_q.push_back(e);
  endtask

  // Monitor: any output change or pulse is an event and must match the queue head.
  initial begin
    logic [47:0] prev_out;
    logic [47:0] cur_out;
    ev_t         cur, req;
    prev_out = '0;
    forever begin
      @(negedge clk);
      cur_out = {digits, digit_point, digit_valid};
      if (!rst_n) begin
        prev_out = cur_out;
      end else if (cur_out != prev_out || frame_done || decode_err || anode_err) begin
        prev_out = cur_out;
        cur = '{cyc: cyc, digits: digits, point: digit_point, valid: digit_valid,
                fd: frame_done, de: decode_err, ae: anode_err};
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL unexpected_event: got cyc=%0d digits=%h point=%h valid=%h fd=%b de=%b ae=%b, required no event",
                   cur.cyc, cur.digits, cur.point, cur.valid, cur.fd, cur.de, cur.ae);
        end else begin
          req = exp_q.pop_front();
          if (cur !== req) begin
            n_miss++;
            $display("FAIL capture_event: got cyc=%0d digits=%h point=%h valid=%h fd=%b de=%b ae=%b, required cyc=%0d digits=%h point=%h valid=%h fd=%b de=%b ae=%b",
                     cur.cyc, cur.digits, cur.point, cur.valid, cur.fd, cur.de, cur.ae,
                     req.cyc, req.digits, req.point, req.valid, req.fd, req.de, req.ae);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] scan_cath [8];
    ev_t        left;
    scan_cath = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80};

    wait_cyc(1);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    wait_cyc(3);

    // Single digit "3" with DP lit
    drive(8'hFE, 8'h30);
    push_cap(0, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_cyc(40);
    drive(8'hFF, 8'hFF);
    wait_cyc(10);

    // Glitch: too short to qualify
    drive(8'hFE, 8'hF9);
    wait_cyc(10);
    drive(8'hFF, 8'hFF);
    wait_cyc(30);

    // Illegal pattern, then blank (invisible), then blank with DP
    drive(8'hFE, 8'hF7);
    push_cap(0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_cyc(25);
    drive(8'hFE, 8'hFF);
    wait_cyc(25);
    drive(8'hFE, 8'h7F);
    push_cap(0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_cyc(25);

    // Two anodes low
    drive(8'hFC, 8'hC0);
    push_anode_err();
    wait_cyc(25);

    // Full scan of digits 1..8
    for (int i = 0; i < 8; i++) begin
      drive(~(8'h01 << i), scan_cath[i]);
      push_cap(i, 4'(i + 1), 1'b1, 1'b0, i == 7, 1'b0);
      wait_cyc(25);
    end
    chk("scan_digits", digits, 32'h87654321);

    // Reset in the middle of a count
    drive(8'hFF, 8'hFF);
    wait_cyc(5);
    drive(8'hFE, 8'hC0);
    repeat (13) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    sh_digits = '0;
    sh_point  = '0;
    sh_valid  = '0;
    wait_cyc(3);
    rst_n = 1'b1;
    cyc0  = cyc;
    push_cap(0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_cyc(30);

    while (exp_q.size() > 0) begin
      left = exp_q.pop_front();
      n_vec++;
      n_miss++;
      $display("FAIL missing_event: got nothing, required cyc=%0d digits=%h valid=%h",
               left.cyc, left.digits, left.valid);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
